// File: rtl/sum_of_squares_seq.sv
// Sum-of-squares front end: X*X + Y*Y through one shared bit-serial shift-add multiplier.
// Valid/ready on both sides; fixed 2W-edge compute latency.
module sum_of_squares_seq #(
  parameter int W  = 32,
  parameter int CW = 7
) (
  input  logic           Clock,
  input  logic           nReset,
  input  logic           InValid,
  output logic           InReady,
  input  logic [W-1:0]   X,
  input  logic [W-1:0]   Y,
  output logic           OutValid,
  input  logic           OutReady,
  output logic [2*W:0]   SumSq,
  output logic           Busy
);

  // state  | meaning
  // S_IDLE | waiting for an operand pair
  // S_SQX  | accumulating opA * opA, one multiplier bit per edge
  // S_SQY  | accumulating opB * opB, result captured on the last edge
  // S_DONE | result presented, waiting for OutReady
  typedef enum logic [1:0] {S_IDLE, S_SQX, S_SQY, S_DONE} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_opa;
  logic [W-1:0]   r_opb;
  logic [2*W:0]   r_acc;
  logic [2*W:0]   r_sumsq;
  logic [CW-1:0]  r_cnt;

  logic [W-1:0]   w_op;
  logic [W-1:0]   w_mask;
  logic           w_bit;
  logic           w_last;
  logic [2*W:0]   w_pp;
  logic [2*W:0]   w_acc_nxt;

  assign w_op      = (r_state == S_SQY) ? r_opb : r_opa;
  assign w_mask    = {{(W-1){1'b0}}, 1'b1} << r_cnt;
  assign w_bit     = |(w_op & w_mask);
  assign w_pp      = {{(W+1){1'b0}}, w_op} << r_cnt;
  assign w_acc_nxt = w_bit ? (r_acc + w_pp) : r_acc;
  assign w_last    = (r_cnt == CW'(W-1));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (InValid)  w_state_nxt = S_SQX;
      S_SQX:   if (w_last)   w_state_nxt = S_SQY;
      S_SQY:   if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  if (OutReady) w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    InReady  = 1'b0;
    Busy     = 1'b0;
    OutValid = 1'b0;
    case (r_state)
      S_IDLE:  InReady  = 1'b1;
      S_SQX,
      S_SQY:   Busy     = 1'b1;
      S_DONE:  OutValid = 1'b1;
      default: InReady  = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sumsq <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (InValid) begin
            r_opa <= X;
            r_opb <= Y;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_SQX, S_SQY: begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          // last Y edge: capture includes the final partial product
          if (r_state == S_SQY && w_last) begin
            r_sumsq <= w_acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign SumSq = r_sumsq;

endmodule

// File: tb/tb_sum_of_squares_seq.sv
// Bench for sum_of_squares_seq (W=8): cycle-level behavioural model plus directed and random vectors.
module tb_sum_of_squares_seq;
  localparam int W  = 8;
  localparam int CW = 4;

  logic           Clock = 1'b0;
  logic           nReset = 1'b0;
  logic           InValid = 1'b0;
  logic           InReady;
  logic [W-1:0]   X = '0;
  logic [W-1:0]   Y = '0;
  logic           OutValid;
  logic           OutReady = 1'b0;
  logic [2*W:0]   SumSq;
  logic           Busy;

  int checks = 0;
  int failures = 0;

  sum_of_squares_seq #(.W(W), .CW(CW)) dut (
    .Clock(Clock), .nReset(nReset), .InValid(InValid), .InReady(InReady),
    .X(X), .Y(Y), .OutValid(OutValid), .OutReady(OutReady),
    .SumSq(SumSq), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 = idle, 1 = computing, 2 = result waiting
  int           m_state = 0;
  int           m_rem = 0;
  logic [2*W:0] m_sum = '0;
  logic [2*W:0] m_pend = '0;
  logic [2*W:0] m_x, m_y;
  logic [2*W:0] sq[$];
  int           n_acc = 0;
  int           n_del = 0;

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      m_state = 0;
      m_sum   = '0;
      sq.delete();
    end else begin
      case (m_state)
        0: if (InValid) begin
             m_x = X; m_y = Y;
             m_pend = m_x * m_x + m_y * m_y;
             sq.push_back(m_pend);
             n_acc++;
             m_rem = 2 * W;
             m_state = 1;
           end
        1: begin
             m_rem--;
             if (m_rem == 0) begin
               m_state = 2;
               m_sum = m_pend;
             end
           end
        default: if (OutReady) m_state = 0;
      endcase
    end
  end

  always @(negedge Clock) begin
    if (nReset) begin
      chk("inready", InReady, m_state == 0);
      chk("busy", Busy, m_state == 1);
      chk("outvalid", OutValid, m_state == 2);
      chk("sumsq", SumSq, m_sum);
      if (OutValid && OutReady) begin
        if (sq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("in_order_result", SumSq, sq.pop_front());
          n_del++;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge Clock); #1;
    X = x; Y = y; InValid = 1'b1;
    @(posedge Clock); #1;
    InValid = 1'b0;
  endtask

  task automatic wait_ov(output int n);
    n = 0;
    while (!OutValid && n < 200) begin
      @(posedge Clock); #1;
      n++;
    end
    if (!OutValid) chk("outvalid_timeout", 0, 1);
  endtask

  task automatic step();
    @(posedge Clock); #1;
    OutReady = 1'($urandom_range(0, 1));
  endtask

  int n, a0, d0, guard;

  initial begin
    #2;
    chk("rst_inready", InReady, 1);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_sumsq", SumSq, 0);
    #15 nReset = 1'b1;

    // basic 3,4
    OutReady = 1'b1;
    send(3, 4);
    chk("t1_inready_low", InReady, 0);
    wait_ov(n);
    chk("t1_latency", n, 16);
    chk("t1_sum", SumSq, 25);
    @(posedge Clock); #1;
    chk("t1_ov_drop", OutValid, 0);
    chk("t1_inready_back", InReady, 1);

    // extremes
    send(255, 255);
    wait_ov(n);
    chk("t2_latency_max", n, 16);
    chk("t2_sum_max", SumSq, 130050);
    @(posedge Clock); #1;
    send(0, 0);
    wait_ov(n);
    chk("t2_latency_zero", n, 16);
    chk("t2_sum_zero", SumSq, 0);
    @(posedge Clock); #1;

    // backpressure
    OutReady = 1'b0;
    send(12, 5);
    wait_ov(n);
    chk("t3_latency", n, 16);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock); #1;
      chk("t3_hold_valid", OutValid, 1);
      chk("t3_hold_sum", SumSq, 169);
    end
    OutReady = 1'b1;
    @(posedge Clock); #1;
    OutReady = 1'b0;
    chk("t3_ov_drop", OutValid, 0);
    chk("t3_inready", InReady, 1);

    // input ignored while busy
    OutReady = 1'b1;
    a0 = n_acc;
    send(6, 8);
    X = 200; Y = 200; InValid = 1'b1;
    wait_ov(n);
    chk("t4_latency", n, 16);
    chk("t4_sum", SumSq, 100);
    chk("t4_one_accept", n_acc - a0, 1);
    @(posedge Clock); #1;
    chk("t4_idle", InReady, 1);
    @(posedge Clock); #1;
    InValid = 1'b0;
    chk("t4_second_accept", n_acc - a0, 2);
    wait_ov(n);
    chk("t4_latency2", n, 16);
    chk("t4_sum2", SumSq, 80000);
    @(posedge Clock); #1;

    // async reset in SQY
    send(100, 100);
    repeat (12) @(posedge Clock);
    #2 nReset = 1'b0;
    #1;
    chk("t5_rst_outvalid", OutValid, 0);
    chk("t5_rst_inready", InReady, 1);
    chk("t5_rst_busy", Busy, 0);
    chk("t5_rst_sumsq", SumSq, 0);
    #4 nReset = 1'b1;
    send(1, 2);
    wait_ov(n);
    chk("t5_latency", n, 16);
    chk("t5_sum", SumSq, 5);
    @(posedge Clock); #1;

    // random pairs with random stalls
    a0 = n_acc;
    d0 = n_del;
    for (int i = 0; i < 200; i++) begin
      guard = 0;
      while (!InReady && guard < 100) begin
        step();
        guard++;
      end
      if (!InReady) chk("t6_accept_timeout", 0, 1);
      X = W'($urandom); Y = W'($urandom); InValid = 1'b1;
      step();
      InValid = 1'b0;
    end
    OutReady = 1'b1;
    guard = 0;
    while ((sq.size() != 0 || m_state != 0) && guard < 100) begin
      @(posedge Clock); #1;
      guard++;
    end
    chk("t6_drain", sq.size(), 0);
    chk("t6_accepts", n_acc - a0, 200);
    chk("t6_delivered", n_del - d0, n_acc - a0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
